// File: rtl/mul_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mul_seq_ctrl
// Description : Sequential 32x32 unsigned shift-add multiplier controller.
//               Drives a shared external adder for one iteration per cycle
//               and returns either the low (MUL) or high (MULHU) product half.
// Revision    : 1.0 - initial release
// ============================================================================
module mul_seq_ctrl #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  input  logic            in_hi,
  input  logic            flush,
  output logic [XLEN-1:0] add_a,
  output logic [XLEN-1:0] add_b,
  input  logic [XLEN-1:0] add_sum,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            busy
);

  localparam logic [1:0]       c_idle = 2'd0;
  localparam logic [1:0]       c_busy = 2'd1;
  localparam logic [1:0]       c_done = 2'd2;
  localparam logic [CNT_W-1:0] c_last = CNT_W'(XLEN - 1);

  logic [1:0]       state_q,  state_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [XLEN-1:0]  p_hi_q,   p_hi_d;
  logic [XLEN-1:0]  p_lo_q,   p_lo_d;
  logic [XLEN-1:0]  m_q,      m_d;
  logic             hi_sel_q, hi_sel_d;

  // The adder has no carry-out, so the lost carry is recovered by noticing
  // that an unsigned sum wrapped below its first operand.
  logic w_carry;
  assign w_carry = p_lo_q[0] & (add_sum < p_hi_q);

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= c_idle;
      cnt_q    <= '0;
      p_hi_q   <= '0;
      p_lo_q   <= '0;
      m_q      <= '0;
      hi_sel_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      p_hi_q   <= p_hi_d;
      p_lo_q   <= p_lo_d;
      m_q      <= m_d;
      hi_sel_q <= hi_sel_d;
    end
  end

  // Next-state and datapath update: load on accept, shift-add while busy.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    p_hi_d   = p_hi_q;
    p_lo_d   = p_lo_q;
    m_d      = m_q;
    hi_sel_d = hi_sel_q;
    case (state_q)
      c_idle: begin
        if (in_valid && !flush) begin
          state_d  = c_busy;
          m_d      = in_a;
          p_lo_d   = in_b;
          p_hi_d   = '0;
          hi_sel_d = in_hi;
          cnt_d    = '0;
        end
      end
      c_busy: begin
        if (flush) begin
          state_d = c_idle;
        end else begin
          // Product shifts right one bit; the sum's LSB drops into P_lo.
          p_hi_d = {w_carry, add_sum[XLEN-1:1]};
          p_lo_d = {add_sum[0], p_lo_q[XLEN-1:1]};
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == c_last) begin
            state_d = c_done;
          end
        end
      end
      c_done: begin
        // A request arriving with out_ready is not taken here; it is
        // accepted from IDLE on the following cycle.
        if (flush || out_ready) begin
          state_d = c_idle;
        end
      end
      default: state_d = c_idle;
    endcase
  end

  // Outputs decoded from the current state; adder operands are zero unless iterating.
  always_comb begin
    in_ready   = (state_q == c_idle);
    busy       = (state_q == c_busy) || (state_q == c_done);
    out_valid  = (state_q == c_done);
    out_result = '0;
    add_a      = '0;
    add_b      = '0;
    if (state_q == c_done) begin
      out_result = hi_sel_q ? p_hi_q : p_lo_q;
    end
    if (state_q == c_busy) begin
      add_a = p_hi_q;
      add_b = p_lo_q[0] ? m_q : '0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mul_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mul_seq_ctrl
// Description : Self-checking bench for mul_seq_ctrl with an ideal adder,
//               a directed vector table, corner sequences and random pairs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_seq_ctrl;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        in_hi;
  logic        flush;
  logic [31:0] add_a;
  logic [31:0] add_b;
  logic [31:0] add_sum;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        busy;

  int n_chk;
  int n_err;

  mul_seq_ctrl #(.XLEN(32), .CNT_W(5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_hi      (in_hi),
    .flush      (flush),
    .add_a      (add_a),
    .add_b      (add_b),
    .add_sum    (add_sum),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .busy       (busy)
  );

  // The shared EX-stage adder: 32-bit, no carry-out.
  assign add_sum = add_a + add_b;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        hi;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference: full 64-bit product, pick the requested half.
  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input logic hi);
    logic [63:0] p;
    p = {32'd0, a} * {32'd0, b};
    return hi ? p[63:32] : p[31:0];
  endfunction

  // Present a request at a negedge; returns at the negedge after the accept edge.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic hi);
    @(negedge clk);
    in_a = a; in_b = b; in_hi = hi; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Wait (bounded) for out_valid; edges counts clock edges after the accept edge.
  task automatic wait_done(output logic [31:0] res, output int edges);
    edges = 0;
    while (!out_valid && edges < 100) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    res = out_result;
  endtask

  task automatic take_result();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] res;
    logic [31:0] ra, rb;
    logic        rh;
    int          edges;
    bit          seen;

    n_chk = 0; n_err = 0;
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_hi = 1'b0;
    flush = 1'b0; out_ready = 1'b0;

    vecs[0] = '{32'd7,        32'd6,        1'b0, 32'h0000_002A};
    vecs[1] = '{32'd7,        32'd6,        1'b1, 32'h0000_0000};
    vecs[2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h0000_0001};
    vecs[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFE};
    vecs[4] = '{32'h8000_0000, 32'h0000_0002, 1'b1, 32'h0000_0001};
    vecs[5] = '{32'h1234_5678, 32'h0000_0000, 1'b0, 32'h0000_0000};
    vecs[6] = '{32'h0000_0000, 32'hDEAD_BEEF, 1'b1, 32'h0000_0000};
    vecs[7] = '{32'h0001_0000, 32'h0001_0000, 1'b1, 32'h0000_0001};

    // Reset state
    #12;
    chk("rst_in_ready",   {31'd0, in_ready},  32'd1);
    chk("rst_busy",       {31'd0, busy},      32'd0);
    chk("rst_out_valid",  {31'd0, out_valid}, 32'd0);
    chk("rst_out_result", out_result,         32'd0);
    chk("rst_add_a",      add_a,              32'd0);
    chk("rst_add_b",      add_b,              32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vector table
    for (int i = 0; i < 8; i++) begin
      start_op(vecs[i].a, vecs[i].b, vecs[i].hi);
      chk("vec_busy", {31'd0, busy}, 32'd1);
      wait_done(res, edges);
      chk($sformatf("vec%0d_latency", i), edges, 32'd32);
      chk($sformatf("vec%0d_result", i), res, vecs[i].exp);
      take_result();
      chk("vec_back_idle", {31'd0, in_ready}, 32'd1);
    end

    // Hold result with out_ready low; extra requests must be ignored
    start_op(32'h0000_1234, 32'h0000_0010, 1'b0);
    wait_done(res, edges);
    chk("hold_latency", edges, 32'd32);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_a = 32'd5; in_b = 32'd5; in_hi = 1'b1;
      chk("hold_out_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_out_result", out_result, 32'h0001_2340);
      chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
      @(posedge clk);
      @(negedge clk);
    end
    // Consume and request in the same cycle: only the consume happens
    in_a = 32'd9; in_b = 32'd9; in_hi = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("consume_only_idle", {31'd0, in_ready}, 32'd1);
    chk("consume_only_busy", {31'd0, busy},     32'd0);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("next_accepted", {31'd0, busy}, 32'd1);
    wait_done(res, edges);
    chk("next_latency", edges, 32'd32);
    chk("next_result", res, 32'd81);
    take_result();

    // Flush in IDLE blocks acceptance
    in_valid = 1'b1; flush = 1'b1; in_a = 32'd2; in_b = 32'd2;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    chk("idle_flush_blocks", {31'd0, busy}, 32'd0);

    // Flush after 10 iterations
    start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    repeat (10) begin
      @(posedge clk);
      @(negedge clk);
    end
    chk("mid_add_a_active", {31'd0, (add_a != 32'd0)}, 32'd1);
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    chk("flush_in_ready",  {31'd0, in_ready},  32'd1);
    chk("flush_busy",      {31'd0, busy},      32'd0);
    chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_add_a",     add_a,              32'd0);
    chk("flush_add_b",     add_b,              32'd0);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("flush_no_result", {31'd0, seen}, 32'd0);
    start_op(32'd123456, 32'd654321, 1'b0);
    wait_done(res, edges);
    chk("post_flush_result", res, ref_mul(32'd123456, 32'd654321, 1'b0));
    take_result();

    // Asynchronous reset mid-operation
    start_op(32'hABCD_0123, 32'h7777_7777, 1'b1);
    repeat (5) begin
      @(posedge clk);
      @(negedge clk);
    end
    #2 rst_n = 1'b0;
    #1;
    chk("arst_in_ready",   {31'd0, in_ready},  32'd1);
    chk("arst_busy",       {31'd0, busy},      32'd0);
    chk("arst_out_valid",  {31'd0, out_valid}, 32'd0);
    chk("arst_out_result", out_result,         32'd0);
    chk("arst_add_a",      add_a,              32'd0);
    chk("arst_add_b",      add_b,              32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    start_op(32'd3, 32'd5, 1'b0);
    wait_done(res, edges);
    chk("post_rst_latency", edges, 32'd32);
    chk("post_rst_result", res, 32'h0000_000F);
    take_result();

    // Random pairs against the 64-bit reference product
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom;
      rb = $urandom;
      rh = 1'($urandom_range(1, 0));
      case ($urandom_range(15, 0))
        0: ra = 32'hFFFF_FFFF;
        1: rb = 32'hFFFF_FFFF;
        2: ra = 32'd0;
        3: rb = 32'd0;
        default: ;
      endcase
      start_op(ra, rb, rh);
      wait_done(res, edges);
      chk("rand_result", res, ref_mul(ra, rb, rh));
      take_result();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mul_seq_ctrl.md
Name: mul_seq_ctrl

Overview:
- Sequential controller that computes a 32x32 unsigned multiply by driving one shared external 32-bit adder (a, b -> sum, no carry-out) in shift-add fashion.
- Sits beside the EX-stage adder; the core stalls on in_ready/out_valid while a MUL/MULHU is in flight.
- Adder operands are exposed as ports so the existing adder instance is reused rather than duplicated.

Parameters:
- XLEN, 32, operand and adder width; only 32 is supported.
- CNT_W, 5, iteration counter width; must equal log2(XLEN).

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  request present.
- in_ready  output  1  controller can accept a request (IDLE only).
- in_a  input  XLEN  multiplicand (unsigned).
- in_b  input  XLEN  multiplier (unsigned).
- in_hi  input  1  0 = return product[31:0] (MUL), 1 = return product[63:32] (MULHU).
- flush  input  1  abort the current operation (pipeline flush).
- add_a  output  XLEN  operand A to the shared adder.
- add_b  output  XLEN  operand B to the shared adder.
- add_sum  input  XLEN  adder result, combinational from add_a/add_b.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts the result.
- out_result  output  XLEN  selected product half.
- busy  output  1  high in BUSY or DONE.

Behaviour:
- States:
  - IDLE: in_ready=1.
  - BUSY: 32 iterations.
  - DONE: out_valid=1, held until accepted.
- Reset (rst_n low, asynchronous, any state):
  - state=IDLE, counter=0, P_hi=0, P_lo=0, M=0, hi_sel=0.
  - out_valid=0, out_result=0, busy=0, in_ready=1.
- IDLE->BUSY on in_valid & in_ready & !flush:
  - load M=in_a, P_lo=in_b, P_hi=0, hi_sel=in_hi, counter=0.
- BUSY, one iteration per cycle:
  - add_a=P_hi; add_b = P_lo[0] ? M : 0.
  - carry = P_lo[0] & (add_sum < P_hi), unsigned compare.
  - next P_hi = {carry, add_sum[31:1]}.
  - next P_lo = {add_sum[0], P_lo[31:1]}.
  - counter increments; when counter==31 the update completes and state->DONE.
- DONE:
  - out_result = hi_sel ? P_hi : P_lo. It is combinational from registers and is 0 when not in DONE.
  - out_valid=1; on out_ready -> IDLE.
- Latency:
  - Acceptance at edge 0; out_valid is first high in the cycle after edge 32 (33 cycles request-to-result).
  - Minimum issue interval 34 cycles with out_ready tied high.
- Adder ports outside BUSY: add_a=0, add_b=0.
- Handshake rules:
  - in_ready=0 in BUSY and DONE; in_valid is ignored there and does not queue.
  - out_result is stable while out_valid=1 and out_ready=0.
- flush (synchronous, highest priority after reset):
  - In BUSY or DONE -> IDLE next edge; the result is discarded and out_valid drops.
  - In IDLE, flush blocks acceptance that cycle.
- Simultaneous out_ready and in_valid in DONE: only the result is consumed; the new request is accepted the following cycle in IDLE.
- Boundary values:
  - in_b=0 or in_a=0 -> product 0.
  - All-ones operands exercise carry on every add.
  - Counter wrap 31->0 coincides with the BUSY->DONE transition.

Test Plan:
- 7 x 6, in_hi=0 -> out_result=0x0000002A after 33 cycles; same with in_hi=1 -> 0x00000000.
- 0xFFFFFFFF x 0xFFFFFFFF -> MUL 0x00000001, MULHU 0xFFFFFFFE (carry path on every iteration).
- 0x80000000 x 0x00000002, in_hi=1 -> 0x00000001; random 1000 pairs checked against a 64-bit reference product.
- Hold out_ready=0 for 10 cycles in DONE -> out_valid and out_result stable, in_ready=0, second in_valid ignored; release -> IDLE, next request accepted.
- flush at iteration 10 -> IDLE next cycle, out_valid never asserts, add_a/add_b return to 0; following request computes correctly.
- rst_n low mid-BUSY (asynchronously, off clock edge) -> outputs immediately at reset values; after release, 3 x 5 -> 0x0000000F.
